// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
//   68000-bus target: answers the asynchronous AS/UDS/LDS/RnW/DTACK handshake
//   for a 32-byte window at BASE_ADDR. It serves sixteen 16-bit mailbox
//   registers to any bus master. A host port reads and writes the same
//   registers from the Pi side.
//
// Optional feature: define MB_DOORBELL_IRQ_EN to add the irq_req output.
//   A bus write to idx 15 sets irq_req. A host write to idx 15 clears it.
//
// Ports
//   sys_clk, sys_rst          clock; synchronous active-high reset
//   nAS_IN/nUDS_IN/nLDS_IN    asynchronous bus strobes (active low)
//   RnW_IN                    asynchronous direction (1 = read)
//   A_IN[23:1], FC_IN, D_IN   address, function code, write data from the bus
//   D_OUT, D_OE               read data and per-bit output enable (lane gated)
//   nDTACK_OUT, nDTACK_OE     open-drain DTACK: OE=1 pulls the line low
//   host_addr/wdata/we        host register write (single-cycle strobe)
//   host_rdata                host read data, one cycle of latency
//   bus_wr_evt, bus_wr_idx    pulse and index after each bus write commits
//   busy                      FSM not idle
//   irq_req                   doorbell request (MB_DOORBELL_IRQ_EN only)
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'hE90000,
    parameter int unsigned DTACK_DELAY = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        nAS_IN,
    input  logic        nUDS_IN,
    input  logic        nLDS_IN,
    input  logic        RnW_IN,
    input  logic [23:1] A_IN,
    input  logic [2:0]  FC_IN,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic [15:0] D_OE,
    output logic        nDTACK_OUT,
    output logic        nDTACK_OE,
    input  logic [3:0]  host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_we,
    output logic [15:0] host_rdata,
    output logic        bus_wr_evt,
    output logic [3:0]  bus_wr_idx,
    output logic        busy
`ifdef MB_DOORBELL_IRQ_EN
    ,
    output logic        irq_req
`endif
);

    localparam logic [3:0] DELAY = DTACK_DELAY[3:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t state, state_n;

    // Strobe synchronisers. They reset to the negated level, so a reset in
    // mid-cycle never looks like a fresh strobe.
    logic [SYNC_STAGES-1:0] as_sync, uds_sync, lds_sync, rnw_sync;
    logic [15:0] d_p1, d_p2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            as_sync  <= '1;
            uds_sync <= '1;
            lds_sync <= '1;
            rnw_sync <= '1;
            d_p1     <= '0;
            d_p2     <= '0;
        end else begin
            as_sync  <= {as_sync[SYNC_STAGES-2:0],  nAS_IN};
            uds_sync <= {uds_sync[SYNC_STAGES-2:0], nUDS_IN};
            lds_sync <= {lds_sync[SYNC_STAGES-2:0], nLDS_IN};
            rnw_sync <= {rnw_sync[SYNC_STAGES-2:0], RnW_IN};
            d_p1     <= D_IN;
            d_p2     <= d_p1;
        end
    end

    logic as_act, uds_act, lds_act, ds_any, rnw_s;
    assign as_act  = ~as_sync[SYNC_STAGES-1];
    assign uds_act = ~uds_sync[SYNC_STAGES-1];
    assign lds_act = ~lds_sync[SYNC_STAGES-1];
    assign ds_any  = uds_act | lds_act;
    assign rnw_s   = rnw_sync[SYNC_STAGES-1];

    // The address and FC lines are stable once AS is seen, so they are read directly.
    logic addr_match;
    assign addr_match = as_act && (A_IN[23:5] == BASE_ADDR[23:5]) && (FC_IN != 3'b111);

    logic [3:0]  cnt;
    logic [3:0]  idx_q;
    logic        rnw_q;
    logic [1:0]  lanes_q;
    logic        commit;
    logic [15:0] regs [0:15];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_n;
    end

    // The counter also decrements in DECODE. For that reason WAIT treats
    // cnt<=1 as expiry: ACK is then entered DTACK_DELAY edges after DECODE
    // is entered (the minimum is 2, because of the DECODE->WAIT hop).
    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            S_IDLE:    if (addr_match) state_n = S_DECODE;
            S_DECODE:  state_n = as_act ? S_WAIT : S_RELEASE;
            S_WAIT: begin
                if (!as_act) begin
                    state_n = S_RELEASE;          // aborted cycle, nothing committed
                end else if ((cnt <= 4'd1) && ds_any) begin
                    state_n = S_ACK;
                    commit  = ~rnw_q;
                end
            end
            S_ACK:     if (!as_act) state_n = S_RELEASE;
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt     <= '0;
            idx_q   <= '0;
            rnw_q   <= 1'b1;
            lanes_q <= '0;
        end else begin
            if (state == S_IDLE && state_n == S_DECODE)
                cnt <= DELAY;
            else if ((state == S_DECODE || state == S_WAIT) && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == S_DECODE) begin
                idx_q <= A_IN[4:1];
                rnw_q <= rnw_s;
            end
            // Lanes seen at the ACK edge keep driving until release.
            if (state == S_WAIT)
                lanes_q <= {uds_act, lds_act};
        end
    end

    // Register file. The host write goes first. A bus commit to the same
    // index then overrides only the lanes it strobed.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            host_rdata <= '0;
            bus_wr_evt <= 1'b0;
            bus_wr_idx <= '0;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (commit) begin
                if (uds_act) regs[idx_q][15:8] <= d_p2[15:8];
                if (lds_act) regs[idx_q][7:0]  <= d_p2[7:0];
                bus_wr_idx <= idx_q;
            end
            host_rdata <= regs[host_addr];
            bus_wr_evt <= commit;
        end
    end

`ifdef MB_DOORBELL_IRQ_EN
    logic host_ring, bus_ring;
    assign host_ring = host_we && (host_addr == 4'hF);
    assign bus_ring  = commit && (idx_q == 4'hF);

    // A same-cycle bus set beats the host clear, unless the host writes bit0=1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            irq_req <= 1'b0;
        else if (bus_ring && !(host_ring && host_wdata[0]))
            irq_req <= 1'b1;
        else if (host_ring)
            irq_req <= 1'b0;
    end
`endif

    // Bus-facing outputs are decoded from registered state, so they cannot glitch.
    always_comb begin
        D_OUT = '0;
        D_OE  = '0;
        if (rnw_q && (state == S_WAIT || state == S_ACK))
            D_OUT = regs[idx_q];
        if (rnw_q && state == S_WAIT)
            D_OE = {{8{uds_act}}, {8{lds_act}}};
        else if (rnw_q && state == S_ACK)
            D_OE = {{8{lanes_q[1]}}, {8{lanes_q[0]}}};
    end

    assign nDTACK_OUT = 1'b0;
    assign nDTACK_OE  = (state == S_ACK);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder (default parameters).
module tb_m68k_bus_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        nAS_IN, nUDS_IN, nLDS_IN, RnW_IN;
    logic [23:1] A_IN;
    logic [2:0]  FC_IN;
    logic [15:0] D_IN;
    logic [15:0] D_OUT, D_OE;
    logic        nDTACK_OUT, nDTACK_OE;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_we;
    logic [15:0] host_rdata;
    logic        bus_wr_evt;
    logic [3:0]  bus_wr_idx;
    logic        busy;
`ifdef MB_DOORBELL_IRQ_EN
    logic        irq_req;
`endif

    m68k_bus_responder dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .nAS_IN(nAS_IN), .nUDS_IN(nUDS_IN), .nLDS_IN(nLDS_IN), .RnW_IN(RnW_IN),
        .A_IN(A_IN), .FC_IN(FC_IN), .D_IN(D_IN),
        .D_OUT(D_OUT), .D_OE(D_OE),
        .nDTACK_OUT(nDTACK_OUT), .nDTACK_OE(nDTACK_OE),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .host_rdata(host_rdata),
        .bus_wr_evt(bus_wr_evt), .bus_wr_idx(bus_wr_idx), .busy(busy)
`ifdef MB_DOORBELL_IRQ_EN
        , .irq_req(irq_req)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int evt_cnt;
    logic [3:0]  evt_idx;
    logic        seen_ack, seen_busy;
    logic [15:0] got_dout, got_doe, rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges and sample 1ns after each one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            if (bus_wr_evt) begin evt_cnt++; evt_idx = bus_wr_idx; end
            if (nDTACK_OE) seen_ack = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
    endtask

    task automatic clr_flags();
        evt_cnt = 0; evt_idx = 4'h0; seen_ack = 1'b0; seen_busy = 1'b0;
    endtask

    task automatic bus_assert(input logic [23:0] addr, input logic [2:0] fc,
                              input logic rnw, input logic [1:0] ds, input logic [15:0] wd);
        A_IN = addr[23:1]; FC_IN = fc; RnW_IN = rnw; D_IN = wd;
        nAS_IN = 1'b0; nUDS_IN = ~ds[1]; nLDS_IN = ~ds[0];
    endtask

    task automatic bus_negate();
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1; RnW_IN = 1'b1;
    endtask

    // Full bus cycle with bounded waits. Read data is captured at DTACK.
    task automatic bus_op(input string tag, input logic [23:0] addr, input logic rnw,
                          input logic [1:0] ds, input logic [15:0] wd);
        int n;
        clr_flags();
        bus_assert(addr, 3'b101, rnw, ds, wd);
        n = 0;
        while (!nDTACK_OE && n < 30) begin tick(1); n++; end
        chk({tag, "_ack"}, {15'd0, nDTACK_OE}, 16'd1);
        got_dout = D_OUT; got_doe = D_OE;
        bus_negate();
        n = 0;
        while (busy && n < 10) begin tick(1); n++; end
        chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
        tick(1);
    endtask

    task automatic hwrite(input logic [3:0] a, input logic [15:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
    endtask

    task automatic hread(input logic [3:0] a, output logic [15:0] d);
        host_addr = a;
        tick(1);
        d = host_rdata;
    endtask

    initial begin
        sys_rst = 1'b1; host_addr = 4'h0; host_wdata = 16'h0; host_we = 1'b0;
        A_IN = '0; FC_IN = 3'b000; D_IN = '0;
        bus_negate();
        clr_flags();
        tick(3);
        chk("rst_doe", D_OE, 16'h0000);
        chk("rst_dtack_oe", {15'd0, nDTACK_OE}, 16'd0);
        chk("rst_dtack_out", {15'd0, nDTACK_OUT}, 16'd0);
        chk("rst_dout", D_OUT, 16'h0000);
        chk("rst_hrdata", host_rdata, 16'h0000);
        chk("rst_evt", {11'd0, bus_wr_evt, bus_wr_idx}, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        sys_rst = 1'b0;
        tick(2);

        // Read of idx 3: DTACK after sync(2)+1+delay(4) = 7 edges.
        bus_assert(24'hE90006, 3'b101, 1'b1, 2'b11, 16'h0);
        tick(3);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        tick(3);
        chk("t1_dtack_early", {15'd0, nDTACK_OE}, 16'd0);
        chk("t1_doe_wait", D_OE, 16'hFFFF);
        tick(1);
        chk("t1_dtack", {15'd0, nDTACK_OE}, 16'd1);
        chk("t1_dout", D_OUT, 16'h0000);
        bus_negate();
        tick(2);
        chk("t1_dtack_hold", {15'd0, nDTACK_OE}, 16'd1);
        tick(1);
        chk("t1_dtack_rel", {15'd0, nDTACK_OE}, 16'd0);
        chk("t1_doe_rel", D_OE, 16'h0000);
        tick(1);
        chk("t1_idle", {15'd0, busy}, 16'd0);
        tick(1);

        // Host write, 1-cycle read latency, then bus reads.
        host_addr = 4'h5; host_wdata = 16'hA55A; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        chk("hr_old", host_rdata, 16'h0000);
        tick(1);
        chk("hr_new", host_rdata, 16'hA55A);
        bus_op("rd5", 24'hE9000A, 1'b1, 2'b11, 16'h0);
        chk("rd5_dout", got_dout, 16'hA55A);
        chk("rd5_doe", got_doe, 16'hFFFF);
        bus_op("rd5u", 24'hE9000A, 1'b1, 2'b10, 16'h0);
        chk("rd5u_doe", got_doe, 16'hFF00);

        // Byte write to the low lane.
        hwrite(4'h1, 16'hFFFF);
        bus_op("wr1", 24'hE90003, 1'b0, 2'b01, 16'hAB12);
        chk("wr1_evt_cnt", evt_cnt[15:0], 16'd1);
        chk("wr1_evt_idx", {12'd0, evt_idx}, 16'd1);
        hread(4'h1, rd);
        chk("wr1_reg", rd, 16'hFF12);

        // Outside the window, or CPU-space FC: ignored.
        clr_flags();
        bus_assert(24'hE80000, 3'b101, 1'b1, 2'b11, 16'h0);
        tick(12);
        chk("nm_addr", {14'd0, seen_ack, seen_busy}, 16'd0);
        bus_negate(); tick(3);
        clr_flags();
        bus_assert(24'hE90000, 3'b111, 1'b1, 2'b11, 16'h0);
        tick(12);
        chk("nm_fc", {14'd0, seen_ack, seen_busy}, 16'd0);
        bus_negate(); tick(3);

        // Collision on idx 2: host 1111 and bus UDS 22xx on the same edge.
        clr_flags();
        bus_assert(24'hE90004, 3'b101, 1'b0, 2'b10, 16'h22AB);
        tick(6);
        host_addr = 4'h2; host_wdata = 16'h1111; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        chk("col_ack", {15'd0, nDTACK_OE}, 16'd1);
        bus_negate(); tick(5);
        hread(4'h2, rd);
        chk("col_reg", rd, 16'h2211);

        // An aborted write in WAIT commits nothing.
        clr_flags();
        bus_assert(24'hE90008, 3'b101, 1'b0, 2'b11, 16'hBEEF);
        tick(4);
        bus_negate();
        tick(6);
        chk("abt_flags", {11'd0, seen_ack, busy, evt_cnt[2:0]}, 16'd0);
        hread(4'h4, rd);
        chk("abt_reg", rd, 16'h0000);

        // A late data strobe keeps the cycle waiting past the delay.
        bus_assert(24'hE90008, 3'b101, 1'b0, 2'b00, 16'hC0DE);
        tick(12);
        chk("late_wait", {14'd0, nDTACK_OE, busy}, 16'h0001);
        nUDS_IN = 1'b0; nLDS_IN = 1'b0;
        tick(2);
        chk("late_noack", {15'd0, nDTACK_OE}, 16'd0);
        tick(1);
        chk("late_ack", {15'd0, nDTACK_OE}, 16'd1);
        bus_negate(); tick(5);
        hread(4'h4, rd);
        chk("late_reg", rd, 16'hC0DE);

`ifdef MB_DOORBELL_IRQ_EN
        bus_op("door", 24'hE9001E, 1'b0, 2'b11, 16'h0000);
        chk("irq_set", {15'd0, irq_req}, 16'd1);
        hwrite(4'hF, 16'h0001);
        chk("irq_clr", {15'd0, irq_req}, 16'd0);
`endif

        // Reset during ACK releases DTACK on the next edge and clears the regs.
        bus_assert(24'hE9000A, 3'b101, 1'b1, 2'b11, 16'h0);
        tick(7);
        chk("ra_ack", {15'd0, nDTACK_OE}, 16'd1);
        sys_rst = 1'b1;
        tick(1);
        chk("ra_rel", {14'd0, nDTACK_OE, busy}, 16'd0);
        chk("ra_doe", D_OE, 16'h0000);
        sys_rst = 1'b0;
        bus_negate();
        hread(4'h5, rd);
        chk("ra_reg", rd, 16'h0000);
`ifdef MB_DOORBELL_IRQ_EN
        chk("ra_irq", {15'd0, irq_req}, 16'd0);
`endif
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
